// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES-128 constants, FSM state type, S-box table and GF(2^8) column helpers.
// Latency: none (pure types and functions).
// Backpressure: not applicable.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} aes_state_e;

  // Forward S-box, entry b lives in bits [8b:8b+7].
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  // Multiply by x, reducing by the AES polynomial on carry-out.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:31] mix_column(input logic [0:31] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[0:7];
    a1 = c[8:15];
    a2 = c[16:23];
    a3 = c[24:31];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic logic [0:127] shift_rows(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-level stream handshakes plus the shared SubBytes datapath bus.
// Latency: none (wiring only).
// Backpressure: valid/ready on input and output streams; the S-box path has fixed latency.
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [0:AES_BLK_W-1] in_pt;
  logic [0:AES_BLK_W-1] in_key;
  logic [0:AES_BLK_W-1] sb_data_o;
  logic [0:AES_BLK_W-1] sb_data_i;
  logic                 out_valid;
  logic                 out_ready;
  logic [0:AES_BLK_W-1] out_ct;

  modport slave (
    input  in_valid, in_pt, in_key, out_ready, sb_data_i,
    output in_ready, out_valid, out_ct, sb_data_o
  );

  modport master (
    output in_valid, in_pt, in_key, out_ready, sb_data_i,
    input  in_ready, out_valid, out_ct, sb_data_o
  );

endinterface

// File: rtl/aes_round_ctrl_key_step.sv
// Next AES-128 round key: RotWord, SubWord through four S-boxes, rcon on byte 0, word chain.
// Latency: combinational.
// Backpressure: none; the caller registers the result when it consumes it.
module s_box
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  assign y_o = sbox(a_i);
endmodule

module aes_key_step
  import aes_pkg::*;
(
  input  logic [0:127] rk_i,
  input  logic [7:0]   rcon_i,
  output logic [0:127] rk_o
);
  logic [0:31] rot_w, sub_w, tmp_w;
  logic [0:31] n0_w, n1_w, n2_w, n3_w;

  // RotWord of the last key word: bytes 13,14,15,12.
  assign rot_w = {rk_i[104:127], rk_i[96:103]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    s_box u_sbox (.a_i(rot_w[8*g +: 8]), .y_o(sub_w[8*g +: 8]));
  end

  assign tmp_w = sub_w ^ {rcon_i, 24'h000000};
  assign n0_w  = rk_i[0:31]   ^ tmp_w;
  assign n1_w  = rk_i[32:63]  ^ n0_w;
  assign n2_w  = rk_i[64:95]  ^ n1_w;
  assign n3_w  = rk_i[96:127] ^ n2_w;
  assign rk_o  = {n0_w, n1_w, n2_w, n3_w};
endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encrypt sequencer sharing one external SubBytes stage; optional flush via AES_ROUND_CTRL_FLUSH_EN.
// Latency: NR*(SB_LAT+1) edges from input accept to out_valid.
// Backpressure: in_ready low while busy (no buffering); out_valid/out_ct held until out_ready.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int SB_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef AES_ROUND_CTRL_FLUSH_EN
  input  logic flush,
`endif
  aes_round_ctrl_if.slave bus
);
  localparam logic [3:0] NR_L      = 4'(NR);
  localparam logic [1:0] WAIT_LAST = 2'(SB_LAT - 1);

  aes_state_e   fsm_q;
  logic [0:127] state_q, rk_q, out_ct_q;
  logic [7:0]   rcon_q;
  logic [3:0]   round_q;
  logic [1:0]   wait_q;
  logic         in_ready_q, out_valid_q;

  logic [0:127] rk_nxt_w, sr_w, mc_w, ark_w;
  logic         flush_w;

`ifdef AES_ROUND_CTRL_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Key for the round being finished, ready while the S-box stage is busy.
  aes_key_step u_key_step (.rk_i(rk_q), .rcon_i(rcon_q), .rk_o(rk_nxt_w));

  assign sr_w = shift_rows(bus.sb_data_i);
  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc_w[32*c +: 32] = mix_column(sr_w[32*c +: 32]);
  end
  // Final round skips MixColumns.
  assign ark_w = ((round_q == NR_L) ? sr_w : mc_w) ^ rk_nxt_w;

  // Round sequencer: accept, wait on S-box stage, mix/add key, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rk_q        <= '0;
      out_ct_q    <= '0;
      rcon_q      <= 8'h01;
      round_q     <= '0;
      wait_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush_w && (fsm_q != IDLE)) begin
      fsm_q       <= IDLE;
      round_q     <= '0;
      wait_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: if (bus.in_valid) begin
          state_q    <= bus.in_pt ^ bus.in_key;
          rk_q       <= bus.in_key;
          round_q    <= 4'd1;
          rcon_q     <= 8'h01;
          wait_q     <= '0;
          in_ready_q <= 1'b0;
          fsm_q      <= SUB;
        end
        SUB: begin
          if (wait_q == WAIT_LAST) begin
            wait_q <= '0;
            fsm_q  <= MIX;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        MIX: begin
          state_q <= ark_w;
          rk_q    <= rk_nxt_w;
          rcon_q  <= xtime(rcon_q);
          if (round_q == NR_L) begin
            out_ct_q    <= ark_w;
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
            fsm_q   <= SUB;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          fsm_q       <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ct    = out_ct_q;
  assign bus.sb_data_o = state_q;

endmodule
